// File: rtl/fwrisc_mem_arb.sv
// fwrisc_mem_arb: merges the fwrisc fetch and data buses onto one memory port,
// data first, with a timeout that completes dead accesses using an error response.
`default_nettype none

module fwrisc_mem_arb #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] iaddr_i,
  input  logic        ivalid_i,
  output logic        iready_o,
  output logic [31:0] idata_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [3:0]  dstrb_i,
  input  logic        dwrite_i,
  input  logic        dvalid_i,
  output logic        dready_o,
  output logic [31:0] drdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_strb_o,
  output logic        mem_write_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_err_o,
  output logic [31:0] err_addr_o
);

  localparam int unsigned CW_RAW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int unsigned TO_M1  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_M1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          iready_q, iready_d;
  logic          dready_q, dready_d;
  logic [31:0]   idata_q, idata_d;
  logic [31:0]   drdata_q, drdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_strb_q, mem_strb_d;
  logic          mem_write_q, mem_write_d;
  logic          mem_req_q, mem_req_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    bus_err_d   = 1'b0;
    idata_d     = idata_q;
    drdata_d    = drdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;
    mem_write_d = mem_write_q;
    mem_req_d   = mem_req_q;
    err_addr_d  = err_addr_q;

    case (state_q)
      IDLE: begin
        if (dvalid_i) begin
          mem_addr_d  = daddr_i;
          mem_wdata_d = dwdata_i;
          mem_strb_d  = dstrb_i;
          mem_write_d = dwrite_i;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = DWAIT;
        end else if (ivalid_i) begin
          mem_addr_d  = iaddr_i;
          mem_wdata_d = 32'h0;
          mem_strb_d  = 4'hF;
          mem_write_d = 1'b0;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = IWAIT;
        end
      end

      IWAIT, DWAIT: begin
        // An ack in the final timeout cycle still counts as a normal completion.
        if (mem_ack_i || timeout_hit) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (state_q == IWAIT) begin
            iready_d = 1'b1;
            idata_d  = mem_ack_i ? mem_rdata_i : ERR_RDATA;
          end else begin
            dready_d = 1'b1;
            if (!mem_write_q) begin
              drdata_d = mem_ack_i ? mem_rdata_i : ERR_RDATA;
            end
          end
          if (!mem_ack_i) begin
            bus_err_d  = 1'b1;
            err_addr_d = mem_addr_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      idata_q     <= 32'h0;
      drdata_q    <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_strb_q  <= 4'h0;
      mem_write_q <= 1'b0;
      mem_req_q   <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
      bus_err_q   <= bus_err_d;
      idata_q     <= idata_d;
      drdata_q    <= drdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      mem_write_q <= mem_write_d;
      mem_req_q   <= mem_req_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign iready_o    = iready_q;
  assign dready_o    = dready_q;
  assign bus_err_o   = bus_err_q;
  assign idata_o     = idata_q;
  assign drdata_o    = drdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_strb_o  = mem_strb_q;
  assign mem_write_o = mem_write_q;
  assign mem_req_o   = mem_req_q;
  assign err_addr_o  = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_mem_arb.sv
// Directed self-checking bench for fwrisc_mem_arb, built with TIMEOUT=4.
`default_nettype none

module tb_fwrisc_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iaddr = '0;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [31:0] idata;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dstrb = '0;
  logic        dwrite = 1'b0;
  logic        dvalid = 1'b0;
  logic        dready;
  logic [31:0] drdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_write;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  fwrisc_mem_arb #(.TIMEOUT(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .iaddr_i(iaddr), .ivalid_i(ivalid), .iready_o(iready), .idata_o(idata),
    .daddr_i(daddr), .dwdata_i(dwdata), .dstrb_i(dstrb), .dwrite_i(dwrite),
    .dvalid_i(dvalid), .dready_o(dready), .drdata_o(drdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_write_o(mem_write), .mem_req_o(mem_req), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .bus_err_o(bus_err), .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_strb", {28'b0, mem_strb}, 32'h0);
    chk("rst_rdy", {30'b0, iready, dready}, 32'h0);
    chk("rst_idata", idata, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Ack with no request is ignored
    mem_ack = 1'b1; mem_rdata = 32'h99;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("stray_ack_rdy", {30'b0, iready, dready}, 32'h0);
    chk("stray_ack_idata", idata, 32'h0);

    // Fetch, zero wait states
    ivalid = 1'b1; iaddr = 32'h100;
    chk("f_c0_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("f_c1_req", {31'b0, mem_req}, 32'h1);
    chk("f_c1_addr", mem_addr, 32'h100);
    chk("f_c1_wr", {31'b0, mem_write}, 32'h0);
    chk("f_c1_strb", {28'b0, mem_strb}, 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'h13;
    tick();
    mem_ack = 1'b0;
    chk("f_c2_iready", {31'b0, iready}, 32'h1);
    chk("f_c2_idata", idata, 32'h13);
    chk("f_c2_req", {31'b0, mem_req}, 32'h0);
    tick();
    ivalid = 1'b0;
    chk("f_c3_iready", {31'b0, iready}, 32'h0);
    chk("f_c3_idata_held", idata, 32'h13);
    tick();

    // Store with two wait states
    dvalid = 1'b1; dwrite = 1'b1; daddr = 32'h2000; dwdata = 32'hA5A5_A5A5; dstrb = 4'h3;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("s_req", {31'b0, mem_req}, 32'h1);
      chk("s_wr", {31'b0, mem_write}, 32'h1);
      chk("s_strb", {28'b0, mem_strb}, 32'h3);
      chk("s_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("s_dready_early", {31'b0, dready}, 32'h0);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("s_c4_dready", {31'b0, dready}, 32'h1);
    chk("s_c4_drdata", drdata, 32'h0);
    chk("s_c4_berr", {31'b0, bus_err}, 32'h0);
    tick();
    dvalid = 1'b0; dwrite = 1'b0;
    chk("s_c5_dready", {31'b0, dready}, 32'h0);
    tick();

    // Simultaneous data and fetch: data first
    ivalid = 1'b1; iaddr = 32'h8;
    dvalid = 1'b1; dwrite = 1'b0; daddr = 32'h40; dstrb = 4'hF;
    tick();
    chk("sim_d_addr", mem_addr, 32'h40);
    chk("sim_d_wr", {31'b0, mem_write}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h11;
    tick();
    mem_ack = 1'b0;
    chk("sim_dready", {31'b0, dready}, 32'h1);
    chk("sim_drdata", drdata, 32'h11);
    chk("sim_iready_early", {31'b0, iready}, 32'h0);
    tick();
    dvalid = 1'b0;
    chk("sim_idle_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("sim_i_addr", mem_addr, 32'h8);
    chk("sim_i_req", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h22;
    tick();
    mem_ack = 1'b0;
    chk("sim_iready", {31'b0, iready}, 32'h1);
    chk("sim_idata", idata, 32'h22);
    tick();
    ivalid = 1'b0;
    tick();

    // Timeout on a load
    dvalid = 1'b1; dwrite = 1'b0; daddr = 32'h3000; dstrb = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to_req_high", {31'b0, mem_req}, 32'h1);
      chk("to_no_ready", {31'b0, dready}, 32'h0);
    end
    tick();
    chk("to_req_low", {31'b0, mem_req}, 32'h0);
    chk("to_dready", {31'b0, dready}, 32'h1);
    chk("to_berr", {31'b0, bus_err}, 32'h1);
    chk("to_drdata", drdata, 32'hDEAD_BEEF);
    chk("to_err_addr", err_addr, 32'h3000);
    tick();
    dvalid = 1'b0;
    chk("to_berr_pulse", {31'b0, bus_err}, 32'h0);
    chk("to_dready_pulse", {31'b0, dready}, 32'h0);
    tick();

    // Ack arrives in the final timeout cycle
    dvalid = 1'b1; dwrite = 1'b0; daddr = 32'h50; dstrb = 4'hF;
    tick(); tick(); tick(); tick();
    chk("tie_req", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0;
    chk("tie_dready", {31'b0, dready}, 32'h1);
    chk("tie_berr", {31'b0, bus_err}, 32'h0);
    chk("tie_drdata", drdata, 32'h55);
    chk("tie_err_addr", err_addr, 32'h3000);
    tick();
    dvalid = 1'b0;
    tick();

    // Asynchronous reset mid-fetch
    ivalid = 1'b1; iaddr = 32'h200;
    tick();
    chk("rw_req", {31'b0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req0", {31'b0, mem_req}, 32'h0);
    chk("rw_addr0", mem_addr, 32'h0);
    chk("rw_strb0", {28'b0, mem_strb}, 32'h0);
    chk("rw_idata0", idata, 32'h0);
    chk("rw_drdata0", drdata, 32'h0);
    chk("rw_erraddr0", err_addr, 32'h0);
    ivalid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ivalid = 1'b1; iaddr = 32'h4;
    tick();
    chk("rw_f_addr", mem_addr, 32'h4);
    chk("rw_f_req", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h6F;
    tick();
    mem_ack = 1'b0;
    chk("rw_f_iready", {31'b0, iready}, 32'h1);
    chk("rw_f_idata", idata, 32'h6F);
    tick();
    ivalid = 1'b0;
    chk("rw_f_iready_pulse", {31'b0, iready}, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
